linecode_enc: RTL and testbench

//  Parametrised E1/T1 line-code encoder: NRZ bit stream in, dual-rail pos/neg pulses out.
//  Run-time selectable AMI, HDB3 (E1) or B8ZS (T1) coding; supersedes hdb3_enc in the E1/T1 TX path.

---
 rtl/linecode_enc.sv | 159 +++++++++++++++
 tb/tb_linecode_enc.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/linecode_enc.sv
// E1/T1 line-code encoder: NRZ bits in, dual-rail pos/neg pulses out; AMI, HDB3 or B8ZS.
// Optional bipolar-violation injection port enabled by LINECODE_ENC_ERR_INJ_EN.
module linecode_enc #(
  parameter bit HAS_B8ZS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode_i,
  input  logic       in_data_i,
  input  logic       in_valid_i,
`ifdef LINECODE_ENC_ERR_INJ_EN
  input  logic       inj_bpv_i,
`endif
  output logic       out_pos_o,
  output logic       out_neg_o,
  output logic       out_valid_o
);

  localparam int unsigned LATENCY = HAS_B8ZS ? 8 : 4;
  localparam int unsigned TAG_W   = 2;

  localparam logic [TAG_W-1:0] TAG_Z = 2'd0;
  localparam logic [TAG_W-1:0] TAG_B = 2'd1;
  localparam logic [TAG_W-1:0] TAG_V = 2'd2;

  localparam logic [1:0] MODE_HDB3 = 2'd1;
  localparam logic [1:0] MODE_B8ZS = 2'd2;

  // Window slot 0 is the head, slot LATENCY-1 the oldest (next to emit).
  logic [LATENCY-1:0]            occ_q, occ_d;
  logic [LATENCY-1:0]            data_q, data_d;
  logic [LATENCY-1:0][TAG_W-1:0] tag_q, tag_d, tag_s;
  logic                          last_pol_q, last_pol_d;   // 1: last mark was positive
  logic                          pulse_par_q, pulse_par_d; // 1: odd pulse count since last V
  logic                          out_pos_q, out_pos_d;
  logic                          out_neg_q, out_neg_d;
  logic                          out_valid_q, out_valid_d;

  logic                          hdb3_det;
  logic                          b8zs_det;
  logic [LATENCY-1:0][TAG_W-1:0] b8zs_tags;
  logic [TAG_W-1:0]              emit_tag;
  logic                          b_pol;

  // HDB3 looks at the oldest four slots: full, all zero, none substituted yet.
  always_comb begin
    hdb3_det = (mode_i == MODE_HDB3) &&
               (&occ_q[LATENCY-1 -: 4]) &&
               !(|data_q[LATENCY-1 -: 4]) &&
               (tag_q[LATENCY-1 -: 4] == '0);
  end

  if (HAS_B8ZS) begin : g_b8zs
    assign b8zs_det  = (mode_i == MODE_B8ZS) && (&occ_q) && !(|data_q) && (tag_q == '0);
    assign b8zs_tags = {TAG_Z, TAG_Z, TAG_Z, TAG_V, TAG_B, TAG_Z, TAG_V, TAG_B};
  end else begin : g_no_b8zs
    assign b8zs_det  = 1'b0;
    assign b8zs_tags = '0;
  end

  // Substituted view of the window, used both for the emit and for the shift.
  always_comb begin
    tag_s = tag_q;
    if (b8zs_det) begin
      tag_s = b8zs_tags;
    end else if (hdb3_det) begin
      tag_s[LATENCY-1] = pulse_par_q ? TAG_Z : TAG_B;
      tag_s[LATENCY-2] = TAG_Z;
      tag_s[LATENCY-3] = TAG_Z;
      tag_s[LATENCY-4] = TAG_V;
    end
  end

  assign emit_tag = tag_s[LATENCY-1];

`ifdef LINECODE_ENC_ERR_INJ_EN
  logic [LATENCY-1:0] inj_q, inj_d;

  always_comb begin
    inj_d = inj_q;
    if (in_valid_i) begin
      inj_d = {inj_q[LATENCY-2:0], inj_bpv_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inj_q <= '0;
    end else begin
      inj_q <= inj_d;
    end
  end

  // An injected B repeats the previous polarity instead of alternating.
  assign b_pol = inj_q[LATENCY-1] ? last_pol_q : !last_pol_q;
`else
  assign b_pol = !last_pol_q;
`endif

  always_comb begin
    occ_d       = occ_q;
    data_d      = data_q;
    tag_d       = tag_q;
    last_pol_d  = last_pol_q;
    pulse_par_d = pulse_par_q;
    out_pos_d   = 1'b0;
    out_neg_d   = 1'b0;
    out_valid_d = 1'b0;
    if (in_valid_i) begin
      occ_d       = {occ_q[LATENCY-2:0], 1'b1};
      data_d      = {data_q[LATENCY-2:0], in_data_i};
      tag_d       = {tag_s[LATENCY-2:0], (in_data_i ? TAG_B : TAG_Z)};
      out_valid_d = occ_q[LATENCY-1];
      if (occ_q[LATENCY-1]) begin
        case (emit_tag)
          TAG_B: begin
            out_pos_d   = b_pol;
            out_neg_d   = !b_pol;
            last_pol_d  = b_pol;
            pulse_par_d = !pulse_par_q;
          end
          TAG_V: begin
            out_pos_d   = last_pol_q;
            out_neg_d   = !last_pol_q;
            pulse_par_d = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q       <= '0;
      data_q      <= '0;
      tag_q       <= '0;
      last_pol_q  <= 1'b0;
      pulse_par_q <= 1'b0;
      out_pos_q   <= 1'b0;
      out_neg_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      data_q      <= data_d;
      tag_q       <= tag_d;
      last_pol_q  <= last_pol_d;
      pulse_par_q <= pulse_par_d;
      out_pos_q   <= out_pos_d;
      out_neg_q   <= out_neg_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_pos_o   = out_pos_q;
  assign out_neg_o   = out_neg_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_linecode_enc.sv
// Self-checking bench for linecode_enc (default HAS_B8ZS=1, LATENCY=8).
// Symbols: '.' no strobe, '0' space, '+' positive pulse, '-' negative pulse.
module tb_linecode_enc;

  localparam int L = 8;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic       in_data;
  logic       in_valid;
  logic       out_pos;
  logic       out_neg;
  logic       out_valid;
`ifdef LINECODE_ENC_ERR_INJ_EN
  logic       inj;
`endif

  int errs;
  int checks;

  typedef struct {
    logic       r;
    logic       v;
    logic       d;
    logic [1:0] m;
    byte        e;
    string      nm;
  } vec_t;

  vec_t tbl[$];

  linecode_enc dut (
    .clk        (clk),
    .rst        (rst),
    .mode_i     (mode),
    .in_data_i  (in_data),
    .in_valid_i (in_valid),
`ifdef LINECODE_ENC_ERR_INJ_EN
    .inj_bpv_i  (inj),
`endif
    .out_pos_o  (out_pos),
    .out_neg_o  (out_neg),
    .out_valid_o(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic byte sym_now();
    if (!out_valid) return (out_pos || out_neg) ? "?" : ".";
    if (out_pos && out_neg) return "X";
    if (out_pos) return "+";
    if (out_neg) return "-";
    return "0";
  endfunction

  task automatic check(input string nm, input byte exp);
    byte act;
    act = sym_now();
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got '%c' expected '%c'", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic d, input logic [1:0] m);
    rst = r; in_valid = v; in_data = d; mode = m;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; in_data = 1'b0;
  endtask

  task automatic add(input logic r, input logic v, input logic d, input logic [1:0] m,
                     input byte e, input string nm);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.m = m; x.e = e; x.nm = nm;
    tbl.push_back(x);
  endtask

  // Reset, then one strobe per bit; mode ma for the first sw strobes, mb after.
  task automatic add_pat(input string nm, input logic [1:0] ma, input logic [1:0] mb,
                         input int sw, input string bits, input string syms);
    byte e;
    add(1'b1, 1'b0, 1'b0, ma, ".", {nm, "_rst"});
    for (int i = 0; i < bits.len(); i++) begin
      if (i < L) e = ".";
      else e = syms[i-L];
      add(1'b0, 1'b1, bits[i] == "1", (i < sw) ? ma : mb, e, $sformatf("%s[%0d]", nm, i));
    end
  endtask

  initial begin
    string got;
    string bits;
    int    bad;
    errs = 0; checks = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = 1'b0; mode = 2'd0;
`ifdef LINECODE_ENC_ERR_INJ_EN
    inj = 1'b0;
`endif
    bits = "10000000011111111";

    add_pat("ami", 2'd0, 2'd0, 99, "1101000000000000", "+-0+0000");
    add(1'b0, 1'b0, 1'b0, 2'd0, ".", "ami_idle");
    add(1'b0, 1'b1, 1'b1, 2'd0, "0", "ami_after_idle");
    add_pat("hdb3", 2'd1, 2'd1, 99, bits, "+000+-00-");
    add_pat("b8zs", 2'd2, 2'd2, 99, bits, "+000+-0-+");
    add_pat("rsvd", 2'd3, 2'd3, 99, bits, "+00000000");
    add_pat("mchg", 2'd1, 2'd0, 10, bits, "+000+0000");

    foreach (tbl[k]) begin
      step(tbl[k].r, tbl[k].v, tbl[k].d, tbl[k].m);
      check(tbl[k].nm, tbl[k].e);
    end

    // HDB3 pattern with a strobe only every third cycle.
    step(1'b1, 1'b0, 1'b0, 2'd1);
    check("gap_rst", ".");
    got = "";
    bad = 0;
    for (int i = 0; i < bits.len(); i++) begin
      step(1'b0, 1'b1, bits[i] == "1", 2'd1);
      if (sym_now() != ".") got = $sformatf("%s%c", got, sym_now());
      for (int g = 0; g < 2; g++) begin
        step(1'b0, 1'b0, 1'b0, 2'd1);
        if (sym_now() != ".") bad++;
      end
    end
    checks++;
    if (got != "+000+-00-") begin
      errs++;
      $display("FAIL gap_seq: got %s expected +000+-00-", got);
    end
    checks++;
    if (bad != 0) begin
      errs++;
      $display("FAIL gap_idle: got %0d outputs on idle cycles expected 0", bad);
    end

    // Reset after a positive mark has gone out: window and polarity restart.
    step(1'b1, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < L; i++) step(1'b0, 1'b1, 1'b1, 2'd0);
    step(1'b0, 1'b1, 1'b1, 2'd0);
    check("pre_rst_mark", "+");
    step(1'b1, 1'b1, 1'b1, 2'd0);
    check("rst_mid", ".");
    bad = 0;
    for (int i = 0; i < L; i++) begin
      step(1'b0, 1'b1, 1'b1, 2'd0);
      if (sym_now() != ".") bad++;
    end
    checks++;
    if (bad != 0) begin
      errs++;
      $display("FAIL rst_fill: got %0d outputs during refill expected 0", bad);
    end
    step(1'b0, 1'b1, 1'b0, 2'd0);
    check("rst_first", "+");
    step(1'b0, 1'b1, 1'b0, 2'd0);
    check("rst_second", "-");

`ifdef LINECODE_ENC_ERR_INJ_EN
    // Injected violation on the second mark; the third mark alternates from it.
    step(1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 1'b1, 2'd0);
    inj = 1'b1;
    step(1'b0, 1'b1, 1'b1, 2'd0);
    inj = 1'b0;
    step(1'b0, 1'b1, 1'b1, 2'd0);
    for (int i = 3; i < L; i++) step(1'b0, 1'b1, 1'b0, 2'd0);
    step(1'b0, 1'b1, 1'b0, 2'd0);
    check("inj_m1", "+");
    step(1'b0, 1'b1, 1'b0, 2'd0);
    check("inj_m2", "+");
    step(1'b0, 1'b1, 1'b0, 2'd0);
    check("inj_m3", "-");
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
